// File: rtl/td4_prog_loader.sv
// td4_prog_loader: host-side program loader for the TD4 CPU tile.
// The host sends bytes over a 4-phase strobe/ack handshake. Each byte is
// written into the CPU program RAM, and the CPU stays in reset until the
// whole program has been written.
// Optional feature macro: TD4_LOADER_CHECKSUM_EN. When it is defined, the
// host sends one more byte after the program. That byte must equal the
// 8-bit sum of the program bytes, otherwise the loader goes to an error
// state and keeps the CPU held.
module td4_prog_loader #(
    parameter int DEPTH       = 16,
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_start,
    input  logic              boot_skip,
    input  logic              strobe,
    input  logic [DATA_W-1:0] data_in,
    output logic              data_ack,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_ACK     = 3'd3,
        ST_DONE    = 3'd4
`ifdef TD4_LOADER_CHECKSUM_EN
        ,
        ST_CK_WAIT = 3'd5,
        ST_CK_ACK  = 3'd6,
        ST_ERR     = 3'd7
`endif
    } state_t;

    state_t                  state_r;
    state_t                  state_next_s;
    logic [SYNC_STAGES-1:0]  ls_sync_r;
    logic [SYNC_STAGES-1:0]  stb_sync_r;
    logic                    ls_prev_r;
    logic                    ls_rise_s;
    logic                    stb_s;
    logic [ADDR_W-1:0]       mem_addr_r;
    logic [ADDR_W-1:0]       addr_next_s;
    logic [DATA_W-1:0]       mem_wdata_r;
    logic [DATA_W-1:0]       wdata_next_s;
    logic                    mem_we_r;
    logic                    data_ack_r;
    logic                    cpu_hold_r;
    logic                    load_done_r;

`ifdef TD4_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0]       sum_r;
    logic [DATA_W-1:0]       sum_next_s;
    logic                    ck_ok_r;
    logic                    ck_ok_next_s;
    logic                    load_err_r;

    // Running checksum: add one program byte, dropping the carry.
    function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] acc,
                                                   input logic [DATA_W-1:0] byte_in);
        return acc + byte_in;
    endfunction
`endif

    // The synchronized strobe level and a one-cycle pulse on each load_start rise.
    assign stb_s     = stb_sync_r[SYNC_STAGES-1];
    assign ls_rise_s = ls_sync_r[SYNC_STAGES-1] & ~ls_prev_r;

    // Synchronizer chains for the asynchronous host inputs, plus the edge-detect history.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ls_sync_r  <= {SYNC_STAGES{1'b0}};
            stb_sync_r <= {SYNC_STAGES{1'b0}};
            ls_prev_r  <= 1'b0;
        end else begin
            ls_sync_r  <= {ls_sync_r[SYNC_STAGES-2:0], load_start};
            stb_sync_r <= {stb_sync_r[SYNC_STAGES-2:0], strobe};
            ls_prev_r  <= ls_sync_r[SYNC_STAGES-1];
        end
    end

    // Next-state, address, data and checksum decisions for the handshake sequencer.
    always_comb begin
        state_next_s = state_r;
        addr_next_s  = mem_addr_r;
        wdata_next_s = mem_wdata_r;
`ifdef TD4_LOADER_CHECKSUM_EN
        sum_next_s   = sum_r;
        ck_ok_next_s = ck_ok_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (ls_rise_s) begin
                    state_next_s = ST_WAIT;
                    addr_next_s  = ADDR_ZERO;
`ifdef TD4_LOADER_CHECKSUM_EN
                    sum_next_s   = {DATA_W{1'b0}};
`endif
                end else if (boot_skip) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (stb_s) begin
                    state_next_s = ST_WRITE;
                    wdata_next_s = data_in;
`ifdef TD4_LOADER_CHECKSUM_EN
                    sum_next_s   = csum_add(sum_r, data_in);
`endif
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_WRITE: begin
                state_next_s = ST_ACK;
            end
            ST_ACK: begin
                if (!stb_s) begin
                    if (mem_addr_r == ADDR_LAST) begin
`ifdef TD4_LOADER_CHECKSUM_EN
                        state_next_s = ST_CK_WAIT;
`else
                        state_next_s = ST_DONE;
`endif
                    end else begin
                        addr_next_s  = mem_addr_r + ADDR_ONE;
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_ACK;
                end
            end
            ST_DONE: begin
                if (ls_rise_s) begin
                    state_next_s = ST_WAIT;
                    addr_next_s  = ADDR_ZERO;
`ifdef TD4_LOADER_CHECKSUM_EN
                    sum_next_s   = {DATA_W{1'b0}};
`endif
                end else begin
                    state_next_s = ST_DONE;
                end
            end
`ifdef TD4_LOADER_CHECKSUM_EN
            ST_CK_WAIT: begin
                if (stb_s) begin
                    state_next_s = ST_CK_ACK;
                    ck_ok_next_s = (data_in == sum_r);
                end else begin
                    state_next_s = ST_CK_WAIT;
                end
            end
            ST_CK_ACK: begin
                if (!stb_s) begin
                    state_next_s = ck_ok_r ? ST_DONE : ST_ERR;
                end else begin
                    state_next_s = ST_CK_ACK;
                end
            end
            ST_ERR: begin
                if (ls_rise_s) begin
                    state_next_s = ST_WAIT;
                    addr_next_s  = ADDR_ZERO;
                    sum_next_s   = {DATA_W{1'b0}};
                end else begin
                    state_next_s = ST_ERR;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
                addr_next_s  = ADDR_ZERO;
            end
        endcase
    end

    // State register and registered outputs. The write pulse and ack follow
    // the state by one cycle; the hold and done flags follow the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            mem_addr_r  <= ADDR_ZERO;
            mem_wdata_r <= {DATA_W{1'b0}};
            mem_we_r    <= 1'b0;
            data_ack_r  <= 1'b0;
            cpu_hold_r  <= 1'b1;
            load_done_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            mem_addr_r  <= addr_next_s;
            mem_wdata_r <= wdata_next_s;
            mem_we_r    <= (state_r == ST_WRITE);
`ifdef TD4_LOADER_CHECKSUM_EN
            data_ack_r  <= (state_r == ST_ACK) || (state_r == ST_CK_ACK);
`else
            data_ack_r  <= (state_r == ST_ACK);
`endif
            cpu_hold_r  <= (state_next_s != ST_DONE);
            load_done_r <= (state_next_s == ST_DONE);
        end
    end

`ifdef TD4_LOADER_CHECKSUM_EN
    // Checksum accumulator, compare result and error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_r      <= {DATA_W{1'b0}};
            ck_ok_r    <= 1'b0;
            load_err_r <= 1'b0;
        end else begin
            sum_r      <= sum_next_s;
            ck_ok_r    <= ck_ok_next_s;
            load_err_r <= (state_next_s == ST_ERR);
        end
    end

    assign load_err = load_err_r;
`else
    assign load_err = 1'b0;
`endif

    assign mem_we    = mem_we_r;
    assign mem_addr  = mem_addr_r;
    assign mem_wdata = mem_wdata_r;
    assign data_ack  = data_ack_r;
    assign cpu_hold  = cpu_hold_r;
    assign load_done = load_done_r;

endmodule

// File: tb/tb_td4_prog_loader.sv
// Self-checking bench for td4_prog_loader. The reference model is a queue
// of expected (address, byte) writes plus an expected program image. It is
// built from the host's point of view: byte k of a load lands at address k.
module tb_td4_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_start;
    logic       boot_skip;
    logic       strobe;
    logic [7:0] data_in;
    logic       data_ack;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_done;
    logic       load_err;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    int         checks = 0;
    int         errors = 0;
    wr_t        exp_q[$];
    logic [7:0] exp_mem [16];
    logic [7:0] shadow [16];
    int         exp_idx = 0;
    logic [7:0] exp_sum = 8'h00;

    td4_prog_loader #(
        .DEPTH(16), .ADDR_W(4), .DATA_W(8), .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .boot_skip(boot_skip),
        .strobe(strobe), .data_in(data_in), .data_ack(data_ack), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_hold(cpu_hold),
        .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Per-cycle compare: every write must be the next expected one.
    always @(negedge clk) begin
        wr_t w;
        if (!rst) begin
            chk("done_is_not_hold", 32'(load_done), 32'(!cpu_hold));
`ifndef TD4_LOADER_CHECKSUM_EN
            chk("load_err_zero", 32'(load_err), 32'h0);
`endif
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_write addr=%0h data=%0h required=no_write", mem_addr, mem_wdata);
                end else begin
                    w = exp_q.pop_front();
                    chk("write_addr", 32'(mem_addr), 32'(w.a));
                    chk("write_data", 32'(mem_wdata), 32'(w.d));
                end
                shadow[mem_addr] = mem_wdata;
            end
        end
    end

    task automatic wait_ack(input logic lvl, input string name);
        int n = 0;
        while (data_ack !== lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (data_ack !== lvl) begin
            checks++;
            errors++;
            $display("FAIL %s timeout data_ack=%0b required=%0b", name, data_ack, lvl);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_q.push_back('{a: 4'(exp_idx), d: d});
        exp_mem[exp_idx] = d;
        exp_idx++;
        exp_sum = exp_sum + d;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit is_mem);
        data_in = d;
        if (is_mem) expect_byte(d);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        strobe = 1'b1;
        wait_ack(1'b1, "ack_rise");
        repeat ($urandom_range(0, 3)) @(negedge clk);
        strobe = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic pulse_load_start();
        @(negedge clk);
        load_start = 1'b1;
        repeat (3) @(negedge clk);
        load_start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic start_load();
        exp_idx = 0;
        exp_sum = 8'h00;
        pulse_load_start();
        chk("hold_after_start", 32'(cpu_hold), 32'h1);
        chk("done_after_start", 32'(load_done), 32'h0);
    endtask

    task automatic finish_load();
`ifdef TD4_LOADER_CHECKSUM_EN
        send_byte(exp_sum, 1'b0);
        chk("ck_err_good", 32'(load_err), 32'h0);
`endif
        chk("load_done_end", 32'(load_done), 32'h1);
        chk("cpu_hold_end", 32'(cpu_hold), 32'h0);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        for (int k = 0; k < 16; k++) chk("image", 32'(shadow[k]), 32'(exp_mem[k]));
    endtask

    task automatic stray_strobes();
        for (int p = 0; p < 3; p++) begin
            @(negedge clk);
            strobe = 1'b1;
            repeat ($urandom_range(1, 4)) begin
                @(negedge clk);
                chk("stray_no_ack", 32'(data_ack), 32'h0);
            end
            strobe = 1'b0;
            repeat (4) begin
                @(negedge clk);
                chk("stray_no_ack", 32'(data_ack), 32'h0);
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        strobe = 1'b0;
        load_start = 1'b0;
        boot_skip = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        load_start = 1'b0;
        boot_skip = 1'b0;
        strobe = 1'b0;
        data_in = 8'h00;
        for (int k = 0; k < 16; k++) begin
            shadow[k] = 8'h00;
            exp_mem[k] = 8'h00;
        end
        repeat (3) @(negedge clk);
        // Reset values while rst is held.
        chk("rst_hold", 32'(cpu_hold), 32'h1);
        chk("rst_done", 32'(load_done), 32'h0);
        chk("rst_ack", 32'(data_ack), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        chk("rst_addr", 32'(mem_addr), 32'h0);
        chk("rst_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_err", 32'(load_err), 32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_hold", 32'(cpu_hold), 32'h1);

        // Strobes in IDLE are ignored.
        stray_strobes();

        // Fixed program 0x10..0x1F.
        start_load();
        for (int k = 0; k < 16; k++) send_byte(8'h10 + 8'(k), 1'b1);
        finish_load();
        chk("pin_first", 32'(shadow[0]), 32'h10);
        chk("pin_last", 32'(shadow[15]), 32'h1F);
        stray_strobes();

        // Synchronizer latency, then a long strobe giving a single write.
        start_load();
        data_in = 8'hA5;
        expect_byte(8'hA5);
        strobe = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("lat_we_n2", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        chk("lat_we_n3", 32'(mem_we), 32'h1);
        chk("lat_ack_n3", 32'(data_ack), 32'h0);
        chk("lat_addr_n3", 32'(mem_addr), 32'h0);
        @(posedge clk); #1;
        chk("lat_we_n4", 32'(mem_we), 32'h0);
        chk("lat_ack_n4", 32'(data_ack), 32'h1);
        repeat (6) @(negedge clk);
        strobe = 1'b0;
        wait_ack(1'b0, "lat_ack_fall");
        for (int k = 1; k < 16; k++) begin
            if (k == 5) pulse_load_start();
            send_byte(8'($urandom), 1'b1);
        end
        finish_load();

        // boot_skip from IDLE releases the CPU without writes.
        do_reset();
        boot_skip = 1'b1;
        @(negedge clk);
        boot_skip = 1'b0;
        @(negedge clk);
        chk("skip_hold", 32'(cpu_hold), 32'h0);
        chk("skip_done", 32'(load_done), 32'h1);
        stray_strobes();
        chk("skip_still_done", 32'(load_done), 32'h1);

        // Randomized loads with ignored load_start pulses and stray strobes.
        for (int l = 0; l < 4; l++) begin
            start_load();
            for (int k = 0; k < 16; k++) begin
                if ($urandom_range(0, 5) == 0) pulse_load_start();
                send_byte(8'($urandom), 1'b1);
            end
            finish_load();
            if ($urandom_range(0, 1) == 1) stray_strobes();
        end

        // Reset asserted while the ack is high.
        start_load();
        send_byte(8'h3C, 1'b1);
        data_in = 8'h5A;
        expect_byte(8'h5A);
        strobe = 1'b1;
        wait_ack(1'b1, "mid_ack_rise");
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_ack", 32'(data_ack), 32'h0);
        chk("mid_rst_hold", 32'(cpu_hold), 32'h1);
        chk("mid_rst_addr", 32'(mem_addr), 32'h0);
        chk("mid_rst_queue", 32'(exp_q.size()), 32'h0);
        @(negedge clk);
        strobe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        stray_strobes();
        chk("idle_hold", 32'(cpu_hold), 32'h1);
        chk("idle_done", 32'(load_done), 32'h0);

`ifdef TD4_LOADER_CHECKSUM_EN
        // Checksum: sixteen 0x01 bytes sum to 0x10.
        start_load();
        for (int k = 0; k < 16; k++) send_byte(8'h01, 1'b1);
        chk("ck_sum_model", 32'(exp_sum), 32'h10);
        send_byte(8'h10, 1'b0);
        chk("ck_good_done", 32'(load_done), 32'h1);
        chk("ck_good_err", 32'(load_err), 32'h0);
        start_load();
        for (int k = 0; k < 16; k++) send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b0);
        chk("ck_bad_err", 32'(load_err), 32'h1);
        chk("ck_bad_hold", 32'(cpu_hold), 32'h1);
        chk("ck_bad_done", 32'(load_done), 32'h0);
        start_load();
        chk("ck_err_cleared", 32'(load_err), 32'h0);
        for (int k = 0; k < 16; k++) send_byte(8'($urandom), 1'b1);
        finish_load();
`endif

        repeat (4) @(negedge clk);
        chk("final_queue_empty", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/td4_prog_loader.md
Name: td4_prog_loader

Overview:
Host-side program loader for the TD4 CPU tile. It receives the 16-byte program from an external host over the uio pins using a 4-phase strobe/ack handshake, and writes each byte into the CPU program memory. It holds the CPU core in reset until the load completes. It sits between the tt_um top-level pins and the CPU's program RAM write port.

Parameters:
DEPTH, 16, number of program bytes per load (power of two)
ADDR_W, 4, program memory address width, log2(DEPTH)
DATA_W, 8, program word width
SYNC_STAGES, 2, flip-flop synchronizer depth on load_start and strobe (min 2)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
load_start  input  1  host request to (re)load the program; asynchronous, synchronized internally
boot_skip  input  1  in IDLE, release the CPU without loading
strobe  input  1  host data-valid, 4-phase handshake; asynchronous, synchronized internally
data_in  input  DATA_W  program byte from host; stable from before strobe rises until ack is seen high
data_ack  output  1  handshake acknowledge to host
mem_we  output  1  program RAM write enable, one-cycle pulse
mem_addr  output  ADDR_W  program RAM write address
mem_wdata  output  DATA_W  program RAM write data (registered)
cpu_hold  output  1  holds CPU core in reset when high
load_done  output  1  program loaded or skipped; CPU running
load_err  output  1  checksum mismatch (CHECKSUM_EN only)

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset values: state=IDLE, mem_addr=0, mem_wdata=0, mem_we=0, data_ack=0, cpu_hold=1, load_done=0, load_err=0. All synchronizer flops clear to 0.
- load_start and strobe pass through SYNC_STAGES flops each. load_start is rising-edge detected after synchronization. strobe is used as a synchronized level (s_stb).
- States:
  - IDLE: cpu_hold=1.
    - load_start rise -> WAIT (addr=0).
    - else boot_skip=1 -> DONE.
    - If both occur in the same cycle, load_start wins.
  - WAIT: s_stb=1 -> WRITE. On this transition, capture data_in into mem_wdata.
  - WRITE: one cycle with mem_we=1 at mem_addr, then -> ACK.
  - ACK: data_ack=1. Stay until s_stb=0. Then:
    - if mem_addr==DEPTH-1 -> DONE;
    - else mem_addr+1 and -> WAIT.
    - data_ack deasserts in the cycle after leaving ACK.
  - DONE: cpu_hold=0, load_done=1, data_ack=0. load_start rise -> WAIT with addr=0, cpu_hold=1, load_done=0.
- Latency: mem_we is high during the clock cycle that starts SYNC_STAGES+1 rising edges after the first edge that samples strobe high. data_ack rises on the next edge.
- mem_addr never wraps inside one load. The last write is at DEPTH-1, and there is no write past it.
- Strobe pulses while in IDLE or DONE produce no write and no ack.
- load_start rises during WAIT, WRITE or ACK are ignored.
- Reset asserted mid-load returns to IDLE immediately. data_ack drops, and a partially written program is left as is.
- A strobe already high when WAIT is entered counts as a new byte.

Optional Feature:
Macro: TD4_LOADER_CHECKSUM_EN.
- Defined:
  - After byte DEPTH-1 completes its ACK, go to CK_WAIT. The address is held and no mem_we is issued.
  - One extra handshaked byte is received. It is compared with the 8-bit modular sum of the DEPTH bytes written in this load. The sum clears on entry to WAIT from IDLE or DONE.
  - Match -> DONE.
  - Mismatch -> ERR: cpu_hold=1, load_err=1, load_done=0.
  - In ERR, a load_start rise restarts at WAIT and clears load_err.
- Undefined: load_err is tied 0, and there are no checksum states or logic.

Test Plan:
1. Reset with rst high, then low -> cpu_hold=1, load_done=0, data_ack=0, mem_we=0 and all outputs at their reset values. Assert rst mid-ACK -> data_ack=0 on the same edge, state IDLE.
2. Load bytes 0x10..0x1F with full handshakes -> exactly 16 mem_we pulses, addr 0..15 carrying data 0x10..0x1F. cpu_hold falls and load_done rises after the 16th ack completes.
3. SYNC_STAGES=2: strobe rises just before edge N -> mem_we high in the cycle after edge N+3, data_ack high after edge N+4. Hold strobe high for 10 cycles -> still one write only.
4. boot_skip=1 from IDLE -> DONE, no mem_we, cpu_hold=0. Then a load_start pulse -> cpu_hold=1 and the next write goes to addr 0.
5. Strobe pulses in IDLE and DONE, and load_start pulses during a load -> no writes, no ack, address sequence unaffected.
6. With TD4_LOADER_CHECKSUM_EN: bytes 0x01 x16 then checksum 0x10 -> DONE. Checksum 0x11 -> load_err=1, cpu_hold=1. A following load_start -> load_err=0.
